// File: rtl/fnd_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | fnd_capture: snoops a scanned 4-digit 7-segment bus and publishes the  |
// | displayed value as binary.                       Revision: 1.0         |
// +------------------------------------------------------------------------+
module fnd_capture #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fndCom,
  input  logic [7:0]  fndFont,
  output logic [13:0] number,
  output logic        number_valid,
  output logic [3:0]  dp,
  output logic        frame_err
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_SETTLE      = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] C_SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] C_TMO_LAST    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;
  logic [11:0]      prev_q, prev_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [3:0][3:0]  slot_q, slot_d;
  logic [3:0]       filled_q, filled_d;
  logic [3:0]       dp_slot_q, dp_slot_d;
  logic [13:0]      acc_q, acc_d;
  logic [1:0]       k_q, k_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [13:0]      number_q, number_d;
  logic             valid_q, valid_d;
  logic [3:0]       dp_q, dp_d;
  logic             err_q, err_d;

  logic             same;
  logic             one_hot;
  logic [1:0]       idx;
  logic [3:0]       digit;
  logic             digit_ok;
  logic             latch;
  logic             timeout;
  logic [13:0]      acc_next;

  always_comb begin
    one_hot = 1'b1;
    idx     = 2'd0;
    case (com_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  // Blank (all segments off) is a legal leading-digit pattern and reads as 0.
  always_comb begin
    digit_ok = 1'b1;
    digit    = 4'd0;
    case (font_q[6:0])
      7'h40:   digit = 4'd0;
      7'h79:   digit = 4'd1;
      7'h24:   digit = 4'd2;
      7'h30:   digit = 4'd3;
      7'h19:   digit = 4'd4;
      7'h12:   digit = 4'd5;
      7'h02:   digit = 4'd6;
      7'h78:   digit = 4'd7;
      7'h00:   digit = 4'd8;
      7'h10:   digit = 4'd9;
      7'h7F:   digit = 4'd0;
      default: digit_ok = 1'b0;
    endcase
  end

  assign same     = ({com_q, font_q} == prev_q);
  // Fires only on the cycle the counter reaches saturation: one latch per dwell.
  assign latch    = same && (cnt_q == C_SETTLE_LAST) && one_hot;
  assign timeout  = (filled_q != 4'h0) && (tmo_q == C_TMO_LAST);
  assign acc_next = (acc_q << 3) + (acc_q << 1) + {10'd0, slot_q[k_q]};

  always_comb begin
    com_d     = fndCom;
    font_d    = fndFont;
    prev_d    = {com_q, font_q};
    cnt_d     = '0;
    state_d   = state_q;
    slot_d    = slot_q;
    filled_d  = filled_q;
    dp_slot_d = dp_slot_q;
    acc_d     = acc_q;
    k_d       = k_q;
    tmo_d     = tmo_q;
    number_d  = number_q;
    valid_d   = 1'b0;
    dp_d      = dp_q;
    err_d     = 1'b0;

    if (same) begin
      cnt_d = (cnt_q == C_SETTLE) ? cnt_q : cnt_q + CW'(1);
    end

    case (state_q)
      ST_COLLECT: begin
        if (filled_q == 4'hF) begin
          acc_d   = {10'd0, slot_q[3]};
          k_d     = 2'd2;
          tmo_d   = '0;
          state_d = ST_CONVERT;
        end else begin
          tmo_d = (filled_q != 4'h0) ? tmo_q + TW'(1) : '0;
          if (timeout || (latch && !digit_ok)) begin
            err_d     = 1'b1;
            slot_d    = '0;
            filled_d  = 4'h0;
            dp_slot_d = 4'h0;
            tmo_d     = '0;
          end else if (latch) begin
            slot_d[idx]    = digit;
            filled_d[idx]  = 1'b1;
            dp_slot_d[idx] = ~font_q[7];
          end
        end
      end
      ST_CONVERT: begin
        acc_d = acc_next;
        if (k_q == 2'd0) begin
          state_d = ST_PUBLISH;
        end else begin
          k_d = k_q - 2'd1;
        end
      end
      ST_PUBLISH: begin
        number_d = acc_q;
        dp_d     = dp_slot_q;
        valid_d  = 1'b1;
        filled_d = 4'h0;
        state_d  = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      com_q     <= 4'hF;
      font_q    <= 8'hFF;
      prev_q    <= 12'hFFF;
      cnt_q     <= '0;
      state_q   <= ST_COLLECT;
      slot_q    <= '0;
      filled_q  <= 4'h0;
      dp_slot_q <= 4'h0;
      acc_q     <= '0;
      k_q       <= 2'd0;
      tmo_q     <= '0;
      number_q  <= '0;
      valid_q   <= 1'b0;
      dp_q      <= 4'h0;
      err_q     <= 1'b0;
    end else begin
      com_q     <= com_d;
      font_q    <= font_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      slot_q    <= slot_d;
      filled_q  <= filled_d;
      dp_slot_q <= dp_slot_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      tmo_q     <= tmo_d;
      number_q  <= number_d;
      valid_q   <= valid_d;
      dp_q      <= dp_d;
      err_q     <= err_d;
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign dp           = dp_q;
  assign frame_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_capture.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for fnd_capture: scans frames onto the bus and checks
// publish counts, values, dp bits, error pulses and latency.
module tb_fnd_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  fndCom = 4'hF;
  logic [7:0]  fndFont = 8'hFF;
  logic [13:0] number;
  logic        number_valid;
  logic [3:0]  dp;
  logic        frame_err;

  int n_pass = 0;
  int n_total = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fnd_capture #(.SETTLE_CYC(4), .TIMEOUT_CYC(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .fndCom       (fndCom),
    .fndFont      (fndFont),
    .number       (number),
    .number_valid (number_valid),
    .dp           (dp),
    .frame_err    (frame_err)
  );

  always @(negedge clk) begin
    if (number_valid) valid_cnt++;
    if (frame_err) err_cnt++;
  end

  typedef struct {
    logic [7:0] f3, f2, f1, f0;
    bit         glitch;
    int         ev, ee, num, dpx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Hold one bus value for n cycles, changing just after a rising edge.
  task automatic drive(input logic [3:0] c, input logic [7:0] f, input int n);
    @(posedge clk); #1;
    fndCom  = c;
    fndFont = f;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, lat;

    vecs[0] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0, 1, 0, 1234, 0};
    vecs[1] = '{8'h90, 8'h90, 8'h90, 8'h90, 1'b0, 1, 0, 9999, 0};
    vecs[2] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, 1, 0, 0,    0};
    vecs[3] = '{8'h7F, 8'h92, 8'h82, 8'hF8, 1'b0, 1, 0, 567,  8};
    // Junk on digit1 aborts; the lone digit0 latched afterwards then times out.
    vecs[4] = '{8'h99, 8'hB0, 8'h55, 8'hA4, 1'b0, 0, 2, 567,  8};
    vecs[5] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 1, 0, 4321, 0};
    vecs[6] = '{8'h99, 8'hB0, 8'hA4, 8'hC0, 1'b1, 0, 1, 4321, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_number", int'(number), 0);
    check("reset_valid", int'(number_valid), 0);
    check("reset_dp", int'(dp), 0);
    check("reset_err", int'(frame_err), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      drive(4'b0111, vecs[i].f3, 16);
      drive(4'b1011, vecs[i].f2, 16);
      drive(4'b1101, vecs[i].f1, 16);
      if (vecs[i].glitch) begin
        for (int j = 0; j < 8; j++) drive(4'b1110, (j % 2 == 1) ? 8'hF9 : 8'hC0, 2);
      end else begin
        drive(4'b1110, vecs[i].f0, 16);
      end
      drive(4'hF, 8'hFF, 130);
      @(negedge clk);
      check($sformatf("v%0d_valid_pulses", i), valid_cnt - v0, vecs[i].ev);
      check($sformatf("v%0d_err_pulses", i), err_cnt - e0, vecs[i].ee);
      check($sformatf("v%0d_number", i), int'(number), vecs[i].num);
      check($sformatf("v%0d_dp", i), int'(dp), vecs[i].dpx);
    end

    // Reset while 8765 is being converted.
    v0 = valid_cnt;
    e0 = err_cnt;
    drive(4'b0111, 8'h80, 16);
    drive(4'b1011, 8'hF8, 16);
    drive(4'b1101, 8'h82, 16);
    drive(4'b1110, 8'h92, 1);
    repeat (7) @(posedge clk);
    #1;
    reset   = 1'b1;
    fndCom  = 4'hF;
    fndFont = 8'hFF;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("rst_conv_valid_pulses", valid_cnt - v0, 0);
    check("rst_conv_err_pulses", err_cnt - e0, 0);
    check("rst_conv_number", int'(number), 0);
    check("rst_conv_dp", int'(dp), 0);

    // 0042 with dp on digit2; also measures last-latch-to-valid latency.
    v0 = valid_cnt;
    e0 = err_cnt;
    drive(4'b0111, 8'hC0, 16);
    drive(4'b1011, 8'h40, 16);
    drive(4'b1101, 8'h99, 16);
    drive(4'b1110, 8'hA4, 1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (number_valid && lat == 0) lat = n;
    end
    check("latency_negedges", lat, 12);
    drive(4'hF, 8'hFF, 20);
    @(negedge clk);
    check("f42_valid_pulses", valid_cnt - v0, 1);
    check("f42_err_pulses", err_cnt - e0, 0);
    check("f42_number", int'(number), 42);
    check("f42_dp", int'(dp), 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
